modet_frame_ctrl: RTL and testbench

MODET_FRAME_CTRL -- requirements
Module: modet_frame_ctrl

---
 rtl/modet_frame_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_modet_frame_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modet_frame_ctrl.sv
// ---------------------------------------------------------------------------
// modet_frame_ctrl
//
// Frame sequencer for the motion-detect pipeline.
//
// After a start request it fans each pixel from the frame input FIFO out to
// the grayscale FIFO and the highlight FIFO. A pixel moves only when the
// source has data and both destination FIFOs have room. Once all NPIX pixels
// have been sent, the block waits until the final output FIFO has seen NPIX
// writes. It then pulses done and returns to idle.
//
// Optional feature (compile macro MODET_CTRL_WDOG_EN):
//   This adds a drain watchdog. If the drain phase runs for WDOG_CYCLES
//   consecutive cycles with no output write, the frame is aborted. err is
//   then set, and it stays set until the next start. When the macro is not
//   defined, err is tied low and the drain phase waits indefinitely.
//
// Parameters:
//   WIDTH, HEIGHT  frame geometry (pixels per line, lines per frame)
//   WDOG_CYCLES    idle-cycle limit for the drain watchdog
//
// Ports:
//   clock       sole clock, rising edge
//   reset       asynchronous active-low reset
//   start       one-cycle frame request (honoured only in IDLE)
//   src_empty   frame input FIFO empty
//   src_dout    frame input FIFO head pixel (first-word-fall-through)
//   gs_full     grayscale FIFO full
//   hl_full     highlight FIFO full
//   out_we_mon  monitor of the final output FIFO write enable
//   src_re      frame input FIFO read enable
//   gs_we       grayscale FIFO write enable
//   gs_din      grayscale FIFO data (same as src_dout)
//   hl_we       highlight FIFO write enable
//   hl_din      highlight FIFO data (same as src_dout)
//   busy        high while in FEED or DRAIN
//   done        one-cycle end-of-frame pulse
//   err         watchdog abort flag
//   in_cnt      pixels fanned out this frame
//   out_cnt     output writes counted this frame (saturates at NPIX)
// ---------------------------------------------------------------------------
module modet_frame_ctrl #(
    parameter int WIDTH       = 768,
    parameter int HEIGHT      = 576,
    parameter int WDOG_CYCLES = 4096,
    localparam int NPIX       = WIDTH * HEIGHT,
    localparam int CNT_W      = $clog2(NPIX + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             src_empty,
    input  logic [23:0]      src_dout,
    input  logic             gs_full,
    input  logic             hl_full,
    input  logic             out_we_mon,
    output logic             src_re,
    output logic             gs_we,
    output logic [23:0]      gs_din,
    output logic             hl_we,
    output logic [23:0]      hl_din,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] in_cnt,
    output logic [CNT_W-1:0] out_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] NPIX_C      = CNT_W'(NPIX);
    localparam logic [CNT_W-1:0] NPIX_LAST_C = CNT_W'(NPIX - 1);

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] in_cnt_r;
    logic [CNT_W-1:0] out_cnt_r;
    logic [CNT_W-1:0] out_cnt_nxt_s;
    logic             busy_r;
    logic             done_r;
    logic             xfer_s;
    logic             frame_start_s;
    logic             wdog_trip_s;

    // The three enables are tied to one term, so no FIFO is ever written alone.
    // reset is included so the enables drop together with the reset pin.
    assign xfer_s        = reset && (state_r == FEED) && !src_empty && !gs_full && !hl_full;
    assign frame_start_s = (state_r == IDLE) && start;

    assign src_re = xfer_s;
    assign gs_we  = xfer_s;
    assign hl_we  = xfer_s;
    assign gs_din = src_dout;
    assign hl_din = src_dout;

    assign busy    = busy_r;
    assign done    = done_r;
    assign in_cnt  = in_cnt_r;
    assign out_cnt = out_cnt_r;

    // Next output count: counts monitor pulses only while a frame is active, saturating at NPIX
    always_comb begin
        out_cnt_nxt_s = out_cnt_r;
        if (((state_r == FEED) || (state_r == DRAIN)) && out_we_mon && (out_cnt_r != NPIX_C)) begin
            out_cnt_nxt_s = out_cnt_r + CNT_W'(1);
        end else begin
            out_cnt_nxt_s = out_cnt_r;
        end
    end

    // Next-state logic. DRAIN looks at the next count, so DONE follows the final increment directly
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = FEED;
                else       next_state_s = IDLE;
            end
            FEED: begin
                if (xfer_s && (in_cnt_r == NPIX_LAST_C)) next_state_s = DRAIN;
                else                                     next_state_s = FEED;
            end
            DRAIN: begin
                if (wdog_trip_s)                   next_state_s = DONE;
                else if (out_cnt_nxt_s == NPIX_C)  next_state_s = DONE;
                else                               next_state_s = DRAIN;
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register plus registered busy/done decoded from the next state, so they line up with state_r
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == FEED) || (next_state_s == DRAIN);
            done_r  <= (next_state_s == DONE);
        end
    end

    // Frame counters: cleared when a frame starts, otherwise holding their final values in IDLE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_cnt_r  <= '0;
            out_cnt_r <= '0;
        end else if (frame_start_s) begin
            in_cnt_r  <= '0;
            out_cnt_r <= '0;
        end else begin
            if (xfer_s) in_cnt_r <= in_cnt_r + CNT_W'(1);
            else        in_cnt_r <= in_cnt_r;
            out_cnt_r <= out_cnt_nxt_s;
        end
    end

`ifdef MODET_CTRL_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_r;
    logic              err_r;

    // The watchdog trips on the last silent cycle, so DONE follows exactly WDOG_CYCLES quiet DRAIN cycles
    assign wdog_trip_s = (state_r == DRAIN) && !out_we_mon &&
                         (wdog_cnt_r == WDOG_W'(WDOG_CYCLES - 1));
    assign err = err_r;

    // Watchdog counter: counts consecutive DRAIN cycles without an output write
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wdog_cnt_r <= '0;
        end else if ((state_r != DRAIN) || out_we_mon) begin
            wdog_cnt_r <= '0;
        end else if (wdog_cnt_r != WDOG_W'(WDOG_CYCLES)) begin
            wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1);
        end else begin
            wdog_cnt_r <= wdog_cnt_r;
        end
    end

    // Sticky abort flag, cleared only when the next frame starts
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_r <= 1'b0;
        end else if (frame_start_s) begin
            err_r <= 1'b0;
        end else if (wdog_trip_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
`else
    assign wdog_trip_s = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_modet_frame_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for modet_frame_ctrl with a 4x2 frame (NPIX = 8) and
// WDOG_CYCLES = 16.
//
// Timing scheme: inputs change 1 time unit after each rising edge, and the
// outputs are checked 1 time unit after that.
//
// The watchdog expectations follow MODET_CTRL_WDOG_EN, so the bench must be
// compiled with the same macro setting as the RTL.
// ---------------------------------------------------------------------------
module tb_modet_frame_ctrl;

    localparam int NPIX  = 8;
    localparam int CNT_W = 4;

    logic             clock      = 1'b0;
    logic             reset      = 1'b0;
    logic             start      = 1'b0;
    logic             src_empty  = 1'b1;
    logic [23:0]      src_dout   = 24'h000000;
    logic             gs_full    = 1'b0;
    logic             hl_full    = 1'b0;
    logic             out_we_mon = 1'b0;
    logic             src_re;
    logic             gs_we;
    logic [23:0]      gs_din;
    logic             hl_we;
    logic [23:0]      hl_din;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic [23:0] gs_q[$];
    logic [23:0] hl_q[$];

    typedef struct {
        logic        empty;
        logic        gsf;
        logic        hlf;
        logic [23:0] dout;
        logic        exp_xfer;
        logic [3:0]  exp_in_cnt;
    } vec_t;

    vec_t vecs[15];

    always #5 clock = ~clock;

    modet_frame_ctrl #(
        .WIDTH(4),
        .HEIGHT(2),
        .WDOG_CYCLES(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .src_empty(src_empty),
        .src_dout(src_dout),
        .gs_full(gs_full),
        .hl_full(hl_full),
        .out_we_mon(out_we_mon),
        .src_re(src_re),
        .gs_we(gs_we),
        .gs_din(gs_din),
        .hl_we(hl_we),
        .hl_din(hl_din),
        .busy(busy),
        .done(done),
        .err(err),
        .in_cnt(in_cnt),
        .out_cnt(out_cnt)
    );

    // Record every FIFO write and every done pulse
    always @(posedge clock) begin
        if (gs_we) gs_q.push_back(gs_din);
        if (hl_we) hl_q.push_back(hl_din);
        if (done)  done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_queues();
        check("gs_count", gs_q.size(), NPIX);
        check("hl_count", hl_q.size(), NPIX);
        for (int i = 0; i < NPIX; i++) begin
            if (i < gs_q.size()) check("gs_data", gs_q[i], 24'hA50000 | 24'(i));
            if (i < hl_q.size()) check("hl_data", hl_q[i], 24'hA50000 | 24'(i));
        end
    endtask

    // Streaming frame: hl_full is high on cycles stall_lo..stall_hi, and each transfer
    // is echoed on out_we_mon 3 cycles later (up to n_mon pulses).
    task automatic run_frame(input int stall_lo, input int stall_hi, input int n_mon,
                             input int ncyc, input bit spam, output int err_cyc);
        int         cnt  = 0;
        int         mons = 0;
        logic [2:0] pipe = 3'b000;
        logic       x;
        err_cyc = -1;
        gs_q.delete();
        hl_q.delete();
        do_start();
        for (int c = 0; c < ncyc; c++) begin
            hl_full    = (c >= stall_lo) && (c <= stall_hi);
            src_empty  = 1'b0;
            src_dout   = 24'hA50000 | 24'(cnt);
            out_we_mon = pipe[2] && (mons < n_mon);
            if (out_we_mon) mons++;
            start      = spam && ((c == 3) || (c == 9));
            x          = (cnt < NPIX) && !hl_full;
            #1;
            check("src_re", src_re, x);
            check("gs_we", gs_we, x);
            check("hl_we", hl_we, x);
            if (x) check("gs_din", gs_din, 24'hA50000 | 24'(cnt));
            if (c == 0) check("busy_first", busy, 1'b1);
            if (err && (err_cyc < 0)) err_cyc = c;
            if (x) cnt++;
            pipe = {pipe[1:0], x};
            @(posedge clock);
            #1;
        end
        start      = 1'b0;
        out_we_mon = 1'b0;
        hl_full    = 1'b0;
        src_empty  = 1'b1;
    endtask

    initial begin
        int ec;
        int d0;

        vecs[0]  = '{1'b0, 1'b0, 1'b0, 24'h111111, 1'b1, 4'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 24'h222222, 1'b0, 4'd1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 24'h333333, 1'b0, 4'd1};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 24'h444444, 1'b0, 4'd1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 24'h555555, 1'b1, 4'd1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 24'h666666, 1'b0, 4'd2};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 24'h777777, 1'b0, 4'd2};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 24'h888888, 1'b1, 4'd2};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 24'h999999, 1'b1, 4'd3};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 24'hAAAAAA, 1'b1, 4'd4};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 24'hBBBBBB, 1'b0, 4'd5};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 24'hCCCCCC, 1'b1, 4'd5};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 24'hDDDDDD, 1'b1, 4'd6};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 24'hEEEEEE, 1'b1, 4'd7};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 4'd8};

        // Reset state; src_empty is low, so the enables must stay low anyway
        src_empty = 1'b0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_in_cnt", in_cnt, 4'd0);
        check("rst_out_cnt", out_cnt, 4'd0);
        check("rst_src_re", src_re, 1'b0);
        check("rst_gs_we", gs_we, 1'b0);
        step();
        reset = 1'b1;
        step();
        check("idle_src_re", src_re, 1'b0);
        src_empty = 1'b1;

        // Table-driven frame: transfer qualification, data pass-through, in_cnt
        do_start();
        for (int i = 0; i < 15; i++) begin
            src_empty = vecs[i].empty;
            gs_full   = vecs[i].gsf;
            hl_full   = vecs[i].hlf;
            src_dout  = vecs[i].dout;
            #1;
            check($sformatf("vec%0d_src_re", i), src_re, vecs[i].exp_xfer);
            check($sformatf("vec%0d_gs_we", i), gs_we, vecs[i].exp_xfer);
            check($sformatf("vec%0d_hl_we", i), hl_we, vecs[i].exp_xfer);
            check($sformatf("vec%0d_gs_din", i), gs_din, vecs[i].dout);
            check($sformatf("vec%0d_hl_din", i), hl_din, vecs[i].dout);
            check($sformatf("vec%0d_in_cnt", i), in_cnt, vecs[i].exp_in_cnt);
            step();
        end
        src_empty = 1'b1;
        gs_full   = 1'b0;
        hl_full   = 1'b0;
        check("tbl_busy_drain", busy, 1'b1);
        for (int k = 0; k < NPIX; k++) begin
            out_we_mon = 1'b1;
            #1;
            check("tbl_no_early_done", done, 1'b0);
            step();
        end
        out_we_mon = 1'b0;
        #1;
        check("tbl_done_now", done, 1'b1);
        check("tbl_busy_done", busy, 1'b0);
        check("tbl_out_cnt", out_cnt, 4'd8);
        step();
        check("tbl_done_one", done, 1'b0);

        // Basic frame
        d0 = done_cnt;
        run_frame(100, 99, 8, 20, 1'b0, ec);
        check("basic_done_cnt", done_cnt - d0, 1);
        check("basic_in_cnt", in_cnt, 4'd8);
        check("basic_out_cnt", out_cnt, 4'd8);
        check("basic_busy", busy, 1'b0);
        check_queues();

        // Backpressure on xfers 3-5, plus start pulses while busy
        d0 = done_cnt;
        run_frame(2, 4, 8, 24, 1'b1, ec);
        check("bp_done_cnt", done_cnt - d0, 1);
        check("bp_in_cnt", in_cnt, 4'd8);
        check("bp_out_cnt", out_cnt, 4'd8);
        check("bp_busy", busy, 1'b0);
        check_queues();

        // Monitor pulses in IDLE are ignored
        for (int k = 0; k < 3; k++) begin
            out_we_mon = 1'b1;
            step();
        end
        out_we_mon = 1'b0;
        #1;
        check("idle_mon_out_cnt", out_cnt, 4'd8);
        check("idle_mon_in_cnt", in_cnt, 4'd8);
        check("idle_mon_busy", busy, 1'b0);

        // Mid-frame reset after 5 transfers
        d0 = done_cnt;
        run_frame(100, 99, 8, 5, 1'b0, ec);
        check("mid_in_cnt_pre", in_cnt, 4'd5);
        src_empty = 1'b0;
        reset     = 1'b0;
        #1;
        check("mid_busy", busy, 1'b0);
        check("mid_in_cnt", in_cnt, 4'd0);
        check("mid_out_cnt", out_cnt, 4'd0);
        check("mid_done", done, 1'b0);
        check("mid_src_re", src_re, 1'b0);
        check("mid_hl_we", hl_we, 1'b0);
        step();
        step();
        check("mid_src_re_held", src_re, 1'b0);
        reset     = 1'b1;
        src_empty = 1'b1;
        step();
        step();
        check("mid_no_done", done_cnt - d0, 0);
        d0 = done_cnt;
        run_frame(100, 99, 8, 20, 1'b0, ec);
        check("post_rst_done_cnt", done_cnt - d0, 1);
        check("post_rst_in_cnt", in_cnt, 4'd8);
        check("post_rst_out_cnt", out_cnt, 4'd8);
        check_queues();

        // Only 7 output writes: drain watchdog behaviour
        d0 = done_cnt;
        run_frame(100, 99, 7, 40, 1'b0, ec);
        check("wd_out_cnt", out_cnt, 4'd7);
        check("wd_in_cnt", in_cnt, 4'd8);
`ifdef MODET_CTRL_WDOG_EN
        check("wd_err_cycle", ec, 26);
        check("wd_err", err, 1'b1);
        check("wd_done_cnt", done_cnt - d0, 1);
        check("wd_busy", busy, 1'b0);
`else
        check("wd_err_cycle", ec, -1);
        check("wd_err", err, 1'b0);
        check("wd_done_cnt", done_cnt - d0, 0);
        check("wd_busy_drain", busy, 1'b1);
        out_we_mon = 1'b1;
        step();
        out_we_mon = 1'b0;
        #1;
        check("wd_late_done", done, 1'b1);
        step();
        check("wd_late_busy", busy, 1'b0);
        check("wd_late_out_cnt", out_cnt, 4'd8);
`endif

        // A following frame clears err
        d0 = done_cnt;
        run_frame(100, 99, 8, 20, 1'b0, ec);
        check("final_err", err, 1'b0);
        check("final_done_cnt", done_cnt - d0, 1);
        check("final_out_cnt", out_cnt, 4'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
